// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin token-ring arbiter.
package rr_arb_pkg;

   localparam int unsigned DEF_N        = 4;
   localparam int unsigned DEF_MAX_HOLD = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_ring_arbiter_token_ring.sv
// One-hot priority pointer; on advance it moves to the slot just past the given winner.
module token_ring #(
   parameter int unsigned N = 4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_adv,
   input  logic [W-1:0] i_pos,
   output logic [N-1:0] o_token
);

   logic [N-1:0] r_token;
   logic [N-1:0] w_next;
   logic [W-1:0] w_next_idx;

   always_comb begin
      w_next_idx = (i_pos == W'(N - 1)) ? '0 : i_pos + W'(1);
      w_next     = '0;
      w_next[w_next_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_token <= N'(1);
      end else if (i_adv) begin
         r_token <= w_next;
      end
   end

   assign o_token = r_token;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter: one registered one-hot grant at a time, bounded hold,
// one idle bubble between grants, priority from a one-hot token ring.
module rr_ring_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned N        = DEF_N,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
   localparam int unsigned W  = $clog2(N),
   localparam int unsigned HW = $clog2(MAX_HOLD + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_id,
   output logic [N-1:0] token
);

   // Lower copy masks out positions below the token, so the first set bit of
   // the doubled vector is the first requester at or after the token, wrapping.
   function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] tok);
      logic [2*N-1:0] dbl;
      logic           found;
      logic [W-1:0]   idx;
      dbl   = {r, r & ~(tok - N'(1))};
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(2 * N); i++) begin
         if (!found && dbl[i]) begin
            found = 1'b1;
            idx   = W'(i % int'(N));
         end
      end
      return idx;
   endfunction

   state_t        r_state, w_state_nxt;
   logic [N-1:0]  r_gnt, w_gnt_nxt;
   logic          r_gnt_valid, w_vld_nxt;
   logic [W-1:0]  r_gnt_id, w_id_nxt;
   logic [HW-1:0] r_hold_cnt, w_hold_nxt;
   logic [W-1:0]  w_win;
   logic          w_adv;
   logic [N-1:0]  w_token;

   token_ring #(.N(N)) u_token_ring (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_adv),
      .i_pos   (w_win),
      .o_token (w_token)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_vld_nxt   = r_gnt_valid;
      w_id_nxt    = r_gnt_id;
      w_hold_nxt  = r_hold_cnt;
      w_adv       = 1'b0;
      w_win       = rr_pick(req, w_token);
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_state_nxt        = ST_GRANT;
               w_gnt_nxt          = '0;
               w_gnt_nxt[w_win]   = 1'b1;
               w_vld_nxt          = 1'b1;
               w_id_nxt           = w_win;
               w_hold_nxt         = HW'(1);
               w_adv              = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!req[r_gnt_id] || (r_hold_cnt == HW'(MAX_HOLD))) begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = '0;
               w_vld_nxt   = 1'b0;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + HW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_vld_nxt   = 1'b0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_hold_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_valid <= w_vld_nxt;
         r_gnt_id    <= w_id_nxt;
         r_hold_cnt  <= w_hold_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign token     = w_token;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench: three arbiters (MAX_HOLD 8, 2, 1) share stimulus; each is checked
// against its own cycle-level model plus directed expectations.
module tb_rr_ring_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;

   logic [3:0] gnt_o [3];
   logic       vld_o [3];
   logic [1:0] id_o  [3];
   logic [3:0] tok_o [3];

   int vectors = 0;
   int errors  = 0;

   int mh     [3] = '{8, 2, 1};
   bit m_busy [3];
   int m_id   [3];
   int m_cnt  [3];
   int m_tok  [3];

   always #5 clk = ~clk;

   rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) u_dut0 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_o[0]), .gnt_valid(vld_o[0]), .gnt_id(id_o[0]), .token(tok_o[0]));
   rr_ring_arbiter #(.N(4), .MAX_HOLD(2)) u_dut1 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_o[1]), .gnt_valid(vld_o[1]), .gnt_id(id_o[1]), .token(tok_o[1]));
   rr_ring_arbiter #(.N(4), .MAX_HOLD(1)) u_dut2 (.clk(clk), .rst(rst), .req(req),
      .gnt(gnt_o[2]), .gnt_valid(vld_o[2]), .gnt_id(id_o[2]), .token(tok_o[2]));

   // Reference behaviour: who holds the resource, for how long, and where priority starts.
   task automatic model_step(input int k, input logic [3:0] r, input logic rs);
      bit found;
      if (rs) begin
         m_busy[k] = 0; m_id[k] = 0; m_cnt[k] = 0; m_tok[k] = 0;
      end else if (!m_busy[k]) begin
         found = 0;
         for (int j = 0; j < 4; j++) begin
            if (!found && r[(m_tok[k] + j) % 4]) begin
               found = 1; m_busy[k] = 1; m_id[k] = (m_tok[k] + j) % 4; m_cnt[k] = 1;
               m_tok[k] = (m_id[k] + 1) % 4;
            end
         end
      end else if (!r[m_id[k]] || m_cnt[k] == mh[k]) begin
         m_busy[k] = 0; m_cnt[k] = 0;
      end else begin
         m_cnt[k]++;
      end
   endtask

   task automatic cyc(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k, r, rs);
      #1;
   endtask

   task automatic test_reset;
      logic [3:0] eg;
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b1);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) cyc(4'b0000, 1'b0);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            eg = 4'b0000;
            if (gnt_o[k] !== eg || vld_o[k] !== 1'b0 || id_o[k] !== 2'd0 || tok_o[k] !== 4'b0001) begin
               errors++;
               $display("FAIL reset_idle inst%0d cyc%0d: gnt=%b vld=%b id=%0d tok=%b, want 0000 0 0 0001",
                        k, c, gnt_o[k], vld_o[k], id_o[k], tok_o[k]);
            end
         end
      end
   endtask

   task automatic test_contention;
      logic [3:0] e0, e2, et;
      for (int c = 1; c <= 36; c++) begin
         cyc(4'b1111, 1'b0);
         e0 = ((c - 1) % 9 < 8) ? (4'b0001 << (((c - 1) / 9) % 4)) : 4'b0000;
         et = 4'b0001 << ((((c - 1) / 9) + 1) % 4);
         e2 = ((c - 1) % 2 == 0) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
         vectors++;
         if (gnt_o[0] !== e0 || tok_o[0] !== et) begin
            errors++;
            $display("FAIL contention_hold8 cyc%0d: gnt=%b tok=%b, want %b %b", c, gnt_o[0], tok_o[0], e0, et);
         end
         vectors++;
         if (gnt_o[2] !== e2) begin
            errors++;
            $display("FAIL contention_hold1 cyc%0d: gnt=%b, want %b", c, gnt_o[2], e2);
         end
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (gnt_o[k] !== (m_busy[k] ? (4'b0001 << m_id[k]) : 4'b0000) || vld_o[k] !== m_busy[k] ||
                id_o[k] !== 2'(m_id[k]) || tok_o[k] !== (4'b0001 << m_tok[k])) begin
               errors++;
               $display("FAIL contention_model inst%0d cyc%0d: gnt=%b id=%0d tok=%b, want busy=%0d id=%0d tok=%0d",
                        k, c, gnt_o[k], id_o[k], tok_o[k], m_busy[k], m_id[k], m_tok[k]);
            end
         end
      end
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
   endtask

   task automatic test_early_release_and_wrap;
      logic [3:0] pat [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
      logic [3:0] eg  [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      logic [3:0] et  [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0010};
      for (int c = 0; c < 7; c++) begin
         cyc(pat[c], 1'b0);
         vectors++;
         if (gnt_o[0] !== eg[c] || tok_o[0] !== et[c]) begin
            errors++;
            $display("FAIL release_wrap step%0d: gnt=%b tok=%b, want %b %b", c, gnt_o[0], tok_o[0], eg[c], et[c]);
         end
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (gnt_o[k] !== (m_busy[k] ? (4'b0001 << m_id[k]) : 4'b0000) || vld_o[k] !== m_busy[k] ||
                id_o[k] !== 2'(m_id[k]) || tok_o[k] !== (4'b0001 << m_tok[k])) begin
               errors++;
               $display("FAIL release_wrap_model inst%0d step%0d: gnt=%b id=%0d tok=%b, want busy=%0d id=%0d tok=%0d",
                        k, c, gnt_o[k], id_o[k], tok_o[k], m_busy[k], m_id[k], m_tok[k]);
            end
         end
      end
   endtask

   task automatic test_lone_timeout;
      logic [3:0] e1, e2;
      for (int c = 1; c <= 12; c++) begin
         cyc(4'b0010, 1'b0);
         e1 = ((c - 1) % 3 < 2) ? 4'b0010 : 4'b0000;
         e2 = ((c - 1) % 2 == 0) ? 4'b0010 : 4'b0000;
         vectors++;
         if (gnt_o[1] !== e1 || id_o[1] !== 2'd1 || vld_o[1] !== (e1 != 4'b0000)) begin
            errors++;
            $display("FAIL timeout_hold2 cyc%0d: gnt=%b id=%0d vld=%b, want %b 1", c, gnt_o[1], id_o[1], vld_o[1], e1);
         end
         vectors++;
         if (gnt_o[2] !== e2) begin
            errors++;
            $display("FAIL timeout_hold1 cyc%0d: gnt=%b, want %b", c, gnt_o[2], e2);
         end
      end
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
   endtask

   task automatic test_reset_mid_grant;
      logic       rs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] eg  [5] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
      logic [3:0] et  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      for (int c = 0; c < 5; c++) begin
         cyc(c == 0 ? 4'b0000 : 4'b1000, rs[c]);
         vectors++;
         if (gnt_o[0] !== eg[c] || tok_o[0] !== et[c]) begin
            errors++;
            $display("FAIL reset_mid_grant step%0d: gnt=%b tok=%b, want %b %b", c, gnt_o[0], tok_o[0], eg[c], et[c]);
         end
      end
      cyc(4'b0000, 1'b0);
   endtask

   task automatic test_random;
      logic [3:0] r;
      logic       rs;
      for (int c = 0; c < 400; c++) begin
         r  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) r = 4'b0000;
         rs = ($urandom_range(0, 49) == 0);
         cyc(r, rs);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (gnt_o[k] !== (m_busy[k] ? (4'b0001 << m_id[k]) : 4'b0000) || vld_o[k] !== m_busy[k] ||
                id_o[k] !== 2'(m_id[k]) || tok_o[k] !== (4'b0001 << m_tok[k])) begin
               errors++;
               $display("FAIL random inst%0d cyc%0d req=%b rst=%b: gnt=%b id=%0d tok=%b, want busy=%0d id=%0d tok=%0d",
                        k, c, r, rs, gnt_o[k], id_o[k], tok_o[k], m_busy[k], m_id[k], m_tok[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_contention;
      test_early_release_and_wrap;
      test_lone_timeout;
      test_reset_mid_grant;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
